prog_loader_ctrl: RTL and testbench
===================================

# prog_loader_ctrl

Boot-time program loader that sequences the 128-bit program-write port of the system memory slave. It receives a framed byte stream from a host link (UART/JTAG bridge), packs it into 128-bit words, and issues one `prog_wen` write per word at successive word addresses. It holds the CPU in reset until a frame is loaded and its checksum verifies. It is the only driver of `prog_wen`, `prog_waddr` and `prog_wdata`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1_000_000: idle cycles allowed between accepted bytes inside a frame before an error is flagged.
- `SYNC_BYTE`, default 8'hA5: frame start marker.

Ports:
- `pll_core_cpuclk` input, 1 bit: sole clock.
- `pad_cpu_rst_b` input, 1 bit: reset, **synchronous, active-low**.
- `byte_valid` input, 1 bit: host byte valid.
- `byte_data` input, 8 bits: host byte.
- `byte_ready` output, 1 bit: loader accepts the byte this cycle.
- `prog_wen` output, 1 bit: one-cycle write strobe to memory.
- `prog_waddr` output, 20 bits: 128-bit word address.
- `prog_wdata` output, 128 bits: write data.
- `cpu_hold` output, 1 bit: 1 keeps the CPU in reset.
- `load_done` output, 1 bit: frame loaded and checksum good (sticky).
- `load_err` output, 1 bit: checksum mismatch or timeout.

## Operation
- A byte transfers when `byte_valid && byte_ready`.
- Frame format:
  - `SYNC_BYTE`.
  - 3 bytes of base word address, little-endian; only bits [19:0] are used and bits [23:20] are ignored.
  - 3 bytes of word count N, little-endian, bits [19:0].
  - N×16 data bytes. Byte k of a word lands in bits [8k+7:8k].
  - 1 checksum byte equal to the XOR of all header and data bytes, with the sync byte excluded.
- States and transitions:
  - IDLE: discard bytes until `SYNC_BYTE`, then go to HDR.
  - HDR: collect 6 header bytes, then go to DATA; go to CHECK instead if N==0.
  - DATA: collect 16 bytes, then go to WRITE.
  - WRITE: one cycle. Asserts `prog_wen` and increments the address (wraps 20'hFFFFF→0) and the word counter. Then go to CHECK if the counter equals N, otherwise back to DATA.
  - CHECK: compare the received byte against the running XOR. On match go to DONE; on mismatch go to ERR.
  - DONE: `load_done`=1, `cpu_hold`=0. Bytes are accepted and dropped. Stays here until reset.
  - ERR: `load_err`=1, `cpu_hold`=1. A `SYNC_BYTE` clears `load_err` and goes to HDR; other bytes are dropped.
- Timeout: in HDR, DATA or CHECK, an idle counter resets on each accepted byte. When it reaches `TIMEOUT_CYCLES`-1 with no byte, go to ERR. Memory words already written are not rolled back.
- `byte_ready` is 1 in all states except WRITE.
- `prog_wdata` and `prog_waddr` hold their values outside WRITE. Memory ignores them while `prog_wen`=0.

## Timing
- Reset values, all taking effect on the clock edge with `pad_cpu_rst_b`=0:
  - state IDLE.
  - `prog_wen`=0, `prog_waddr`=0, `prog_wdata`=0.
  - `byte_ready`=1.
  - `cpu_hold`=1, `load_done`=0, `load_err`=0.
  - XOR, counters and timeout counter all 0.
- Reset asserted mid-frame aborts the frame. The next frame must restart from sync.
- `prog_wen` is registered. It is high exactly in the cycle after the 16th data byte of a word is accepted.
- Throughput is at most one word per 17 cycles.
- `cpu_hold` falls and `load_done` rises together, one cycle after the checksum byte is accepted.
- In the cycle `prog_wen`=1 the memory slave returns a fixed read pattern. The CPU is held in reset, so no AXI traffic overlaps.
- A byte offered in the same cycle the timeout fires is not accepted (ERR wins). ERR then treats it as a normal byte on the next cycle.

## Structure
- Shared package `prog_loader_pkg` holds:
  - the state enum (IDLE, HDR, DATA, WRITE, CHECK, DONE, ERR);
  - `PROG_ADDR_W`=20, `PROG_DATA_W`=128;
  - the `HDR_BYTES`=6 and `WORD_BYTES`=16 constants.
- One sub-module is natural: `prog_word_packer`. It is a 16-byte shift/assemble register with a byte index and a `word_full` flag.
- The FSM, counters, XOR and timeout logic stay in the top.

## Test plan
1. Frame A5, addr 00 10 00, N=01 00 00, bytes 00..0F, checksum = XOR:
   - one `prog_wen`, with `prog_waddr`=20'h00010 and `prog_wdata`=128'h0F0E…0100;
   - then `load_done`=1 and `cpu_hold`=0.
2. N=0 frame with checksum 10^00 XOR header = correct:
   - no `prog_wen`;
   - `load_done`=1.
3. Base address 20'hFFFFF, N=2:
   - writes go to FFFFF then 00000 (wrap).
4. Corrupted checksum:
   - `load_err`=1, `cpu_hold` stays 1.
   - A new valid frame then gives `load_err`=0 and `load_done`=1.
5. Stall mid-data with `TIMEOUT_CYCLES`=16:
   - `load_err` rises 16 cycles after the last accepted byte;
   - bytes before the sync marker are ignored.
6. Reset pulse after 8 data bytes, then a full valid frame:
   - only the new frame's words are written;
   - all outputs return to reset values in the reset cycle.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

  localparam int PROG_ADDR_W = 20;
  localparam int PROG_DATA_W = 128;
  localparam int HDR_BYTES   = 6;
  localparam int WORD_BYTES  = 16;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERR
  } state_e;

  // States in which a stalled host link counts towards the timeout.
  function automatic logic is_timed(input state_e s);
    return (s == HDR) || (s == DATA) || (s == CHECK);
  endfunction

endpackage

// File: rtl/prog_word_packer.sv
// Assembles 16 consecutive bytes into one 128-bit word, byte k in bits [8k+7:8k].
// word_o already contains the byte offered this cycle, so the caller can
// capture a complete word on the same edge that accepts its last byte.
module prog_word_packer
  import prog_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   byte_en,
  input  logic [7:0]             byte_data,
  output logic [PROG_DATA_W-1:0] word_o,
  output logic                   word_full
);

  localparam int IDX_W = $clog2(WORD_BYTES);

  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [PROG_DATA_W-1:0] word_q, word_d;

  // Merge the incoming byte at the current index and advance the index.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clr) begin
      idx_d  = '0;
      word_d = '0;
    end else if (byte_en) begin
      word_d[{idx_q, 3'b000} +: 8] = byte_data;
      idx_d                        = idx_q + 1'b1;
    end
  end

  assign word_o    = word_d;
  assign word_full = byte_en && (idx_q == IDX_W'(WORD_BYTES - 1));

  // Byte index and partial word registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/prog_loader_ctrl.sv
// Framed byte-stream program loader: sync, 6-byte header, N x 16 data bytes,
// XOR checksum. Drives the 128-bit program-write port and holds the CPU in
// reset until a frame has loaded with a good checksum.
module prog_loader_ctrl
  import prog_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                   pll_core_cpuclk,
  input  logic                   pad_cpu_rst_b,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  output logic                   prog_wen,
  output logic [PROG_ADDR_W-1:0] prog_waddr,
  output logic [PROG_DATA_W-1:0] prog_wdata,
  output logic                   cpu_hold,
  output logic                   load_done,
  output logic                   load_err
);

  localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [2:0]             hdr_idx_q, hdr_idx_d;
  logic [PROG_ADDR_W-1:0] addr_q, addr_d;
  logic [PROG_ADDR_W-1:0] n_q, n_d;
  logic [PROG_ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [7:0]             xor_q, xor_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   ready_q, ready_d;
  logic                   wen_q, wen_d;
  logic [PROG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [PROG_DATA_W-1:0] wdata_q, wdata_d;
  logic                   hold_q, hold_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   acc;
  logic                   pk_clr, pk_en, pk_full;
  logic [PROG_DATA_W-1:0] pk_word;

  assign acc = byte_valid && ready_q;

  prog_word_packer u_packer (
    .clk       (pll_core_cpuclk),
    .rst_n     (pad_cpu_rst_b),
    .clr       (pk_clr),
    .byte_en   (pk_en),
    .byte_data (byte_data),
    .word_o    (pk_word),
    .word_full (pk_full)
  );

  // Next-state, datapath and registered-output computation for the loader FSM.
  always_comb begin
    state_d   = state_q;
    hdr_idx_d = hdr_idx_q;
    addr_d    = addr_q;
    n_d       = n_q;
    wcnt_d    = wcnt_q;
    xor_d     = xor_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    pk_clr    = 1'b0;
    pk_en     = 1'b0;

    unique case (state_q)
      IDLE, ERR: begin
        if (acc && byte_data == SYNC_BYTE) begin
          state_d   = HDR;
          hdr_idx_d = '0;
          addr_d    = '0;
          n_d       = '0;
          wcnt_d    = '0;
          xor_d     = '0;
          pk_clr    = 1'b1;
        end
      end
      HDR: begin
        if (acc) begin
          xor_d     = xor_q ^ byte_data;
          hdr_idx_d = hdr_idx_q + 1'b1;
          case (hdr_idx_q)
            3'd0:    addr_d[7:0]   = byte_data;
            3'd1:    addr_d[15:8]  = byte_data;
            3'd2:    addr_d[19:16] = byte_data[3:0];
            3'd3:    n_d[7:0]      = byte_data;
            3'd4:    n_d[15:8]     = byte_data;
            default: n_d[19:16]    = byte_data[3:0];
          endcase
          if (hdr_idx_q == 3'(HDR_BYTES - 1))
            state_d = (n_d == '0) ? CHECK : DATA;
        end
      end
      DATA: begin
        if (acc) begin
          xor_d = xor_q ^ byte_data;
          pk_en = 1'b1;
          if (pk_full) begin
            state_d = WRITE;
            waddr_d = addr_q;
            wdata_d = pk_word;
          end
        end
      end
      WRITE: begin
        addr_d  = addr_q + 1'b1;
        wcnt_d  = wcnt_q + 1'b1;
        state_d = (wcnt_d == n_q) ? CHECK : DATA;
      end
      CHECK: begin
        if (acc) state_d = (byte_data == xor_q) ? DONE : ERR;
      end
      default: ;
    endcase

    // Idle timer only runs while a frame is in flight; an expiry overrides
    // any transition (ready is already low in that cycle).
    tmo_d = '0;
    if (is_timed(state_q) && !acc) begin
      if (tmo_q == TMO_LAST) state_d = ERR;
      else                   tmo_d   = tmo_q + 1'b1;
    end

    ready_d = (state_d != WRITE) && !(is_timed(state_d) && tmo_d == TMO_LAST);
    wen_d   = (state_d == WRITE);
    hold_d  = (state_d != DONE);
    done_d  = (state_d == DONE);
    err_d   = (state_d == ERR);
  end

  // Single register bank for FSM state, counters and outputs.
  always_ff @(posedge pll_core_cpuclk) begin
    if (!pad_cpu_rst_b) begin
      state_q   <= IDLE;
      hdr_idx_q <= '0;
      addr_q    <= '0;
      n_q       <= '0;
      wcnt_q    <= '0;
      xor_q     <= '0;
      tmo_q     <= '0;
      ready_q   <= 1'b1;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_idx_q <= hdr_idx_d;
      addr_q    <= addr_d;
      n_q       <= n_d;
      wcnt_q    <= wcnt_d;
      xor_q     <= xor_d;
      tmo_q     <= tmo_d;
      ready_q   <= ready_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign byte_ready = ready_q;
  assign prog_wen   = wen_q;
  assign prog_waddr = waddr_q;
  assign prog_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign load_done  = done_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Bench for prog_loader_ctrl: frames are built from the frame rules
// (header bytes, packed words, XOR checksum) and the DUT write port and status
// outputs are compared against them.
module tb_prog_loader_ctrl;

  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         byte_ready;
  logic         prog_wen;
  logic [19:0]  prog_waddr;
  logic [127:0] prog_wdata;
  logic         cpu_hold;
  logic         load_done;
  logic         load_err;

  int n_checks = 0;
  int n_fail   = 0;
  int wen_cnt  = 0;

  always #5 clk = ~clk;

  prog_loader_ctrl #(.TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)) dut (
    .pll_core_cpuclk (clk),
    .pad_cpu_rst_b   (rst_b),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .byte_ready      (byte_ready),
    .prog_wen        (prog_wen),
    .prog_waddr      (prog_waddr),
    .prog_wdata      (prog_wdata),
    .cpu_hold        (cpu_hold),
    .load_done       (load_done),
    .load_err        (load_err)
  );

  // Count every write strobe seen by memory.
  always @(negedge clk) if (prog_wen === 1'b1) wen_cnt++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte after gap idle cycles; returns one tick after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int guard;
    byte_valid = 1'b0;
    repeat (gap) step();
    byte_valid = 1'b1;
    byte_data  = b;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 100) begin
      acc = byte_ready;
      step();
      guard++;
    end
    byte_valid = 1'b0;
    if (!acc) chk("accept_bound", 128'd0, 128'd1);
  endtask

  task automatic do_reset(input string tag);
    rst_b      = 1'b0;
    byte_valid = 1'b0;
    step();
    chk({tag, "_rst_wen"},   128'(prog_wen),   128'd0);
    chk({tag, "_rst_waddr"}, 128'(prog_waddr), 128'd0);
    chk({tag, "_rst_wdata"}, prog_wdata,       128'd0);
    chk({tag, "_rst_ready"}, 128'(byte_ready), 128'd1);
    chk({tag, "_rst_hold"},  128'(cpu_hold),   128'd1);
    chk({tag, "_rst_done"},  128'(load_done),  128'd0);
    chk({tag, "_rst_err"},   128'(load_err),   128'd0);
    rst_b = 1'b1;
    step();
  endtask

  function automatic logic [7:0] junk_byte();
    logic [7:0] b;
    b = 8'($urandom);
    return (b == 8'hA5) ? 8'h00 : b;
  endfunction

  // Send a whole frame and check every write and the final status against
  // values derived from the frame contents.
  task automatic send_frame(input string tag, input logic [19:0] base, input logic [3:0] hi_junk,
                            input int n, input bit corrupt, input bit seq_data,
                            input bit with_sync, input int gapmax);
    logic [7:0]   hdr [6];
    logic [7:0]   cks;
    logic [7:0]   b;
    logic [127:0] word;
    logic [19:0]  ea;
    logic [23:0]  nn;
    int           start_wen;
    nn     = 24'(n);
    hdr[0] = base[7:0];
    hdr[1] = base[15:8];
    hdr[2] = {hi_junk, base[19:16]};
    hdr[3] = nn[7:0];
    hdr[4] = nn[15:8];
    hdr[5] = nn[23:16];
    cks       = 8'h00;
    start_wen = wen_cnt;
    if (with_sync) send_byte(8'hA5, $urandom_range(gapmax, 0));
    for (int i = 0; i < 6; i++) begin
      cks ^= hdr[i];
      send_byte(hdr[i], $urandom_range(gapmax, 0));
    end
    for (int w = 0; w < n; w++) begin
      word = '0;
      for (int k = 0; k < 16; k++) begin
        b = seq_data ? 8'(k) : 8'($urandom);
        word[8*k +: 8] = b;
        cks ^= b;
        send_byte(b, $urandom_range(gapmax, 0));
      end
      ea = base + 20'(w);
      chk({tag, "_wen"},   128'(prog_wen),   128'd1);
      chk({tag, "_waddr"}, 128'(prog_waddr), 128'(ea));
      chk({tag, "_wdata"}, prog_wdata,       word);
    end
    chk({tag, "_done_early"}, 128'(load_done), 128'd0);
    send_byte(corrupt ? (cks ^ 8'h5A) : cks, $urandom_range(gapmax, 0));
    chk({tag, "_done"},   128'(load_done), 128'(!corrupt));
    chk({tag, "_err"},    128'(load_err),  128'(corrupt));
    chk({tag, "_hold"},   128'(cpu_hold),  128'(corrupt));
    chk({tag, "_nwrite"}, 128'(wen_cnt - start_wen), 128'(n));
  endtask

  initial begin
    int k;
    int start_wen;
    rst_b      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    step();

    // 1: single word, sequential data, base 0x10
    do_reset("t1");
    send_frame("t1", 20'h00010, 4'h0, 1, 1'b0, 1'b1, 1'b1, 0);
    chk("t1_literal", prog_wdata, 128'h0F0E0D0C0B0A09080706050403020100);

    // 2: empty frame
    do_reset("t2");
    send_frame("t2", 20'h12345, 4'h0, 0, 1'b0, 1'b0, 1'b1, 2);

    // 3: address wrap, with ignored high address bits set
    do_reset("t3");
    send_frame("t3", 20'hFFFFF, 4'hB, 2, 1'b0, 1'b0, 1'b1, 1);

    // 4: bad checksum, then recovery from ERR with junk byte first
    do_reset("t4");
    send_frame("t4a", 20'h00200, 4'h0, 1, 1'b1, 1'b0, 1'b1, 1);
    send_byte(8'h3C, 0);
    chk("t4_err_hold", 128'(load_err), 128'd1);
    send_frame("t4b", 20'h00300, 4'h0, 2, 1'b0, 1'b0, 1'b1, 1);

    // 5: junk before sync, then a stall mid-data
    do_reset("t5");
    send_byte(8'h00, 0);
    send_byte(8'h5A, 1);
    send_byte(8'hFF, 0);
    start_wen = wen_cnt;
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    for (int i = 0; i < 5; i++) send_byte(8'(i * 7), 0);
    k = 0;
    while (!load_err && k < 40) begin
      step();
      k++;
    end
    chk("t5_tmo_latency", 128'(k), 128'd16);
    chk("t5_hold", 128'(cpu_hold), 128'd1);
    chk("t5_done", 128'(load_done), 128'd0);
    chk("t5_nwrite", 128'(wen_cnt - start_wen), 128'd0);
    send_frame("t5b", 20'h00500, 4'h0, 1, 1'b0, 1'b0, 1'b1, 1);

    // 5c: byte offered exactly when the timeout fires is deferred to ERR
    do_reset("t5c");
    send_byte(8'hA5, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h03, 0);
    repeat (15) step();
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    chk("t5c_ready_fire", 128'(byte_ready), 128'd0);
    step();
    chk("t5c_err", 128'(load_err), 128'd1);
    chk("t5c_ready_err", 128'(byte_ready), 128'd1);
    step();
    byte_valid = 1'b0;
    chk("t5c_err_clr", 128'(load_err), 128'd0);
    send_frame("t5c", 20'h00700, 4'h0, 1, 1'b0, 1'b0, 1'b0, 1);

    // 6: reset after 8 data bytes, then a clean frame
    do_reset("t6");
    start_wen = wen_cnt;
    send_byte(8'hA5, 0);
    send_byte(8'h40, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
    do_reset("t6mid");
    chk("t6_nwrite_abort", 128'(wen_cnt - start_wen), 128'd0);
    send_frame("t6", 20'h00080, 4'h0, 2, 1'b0, 1'b0, 1'b1, 1);

    // Random frames
    for (int r = 0; r < 6; r++) begin
      int nj;
      do_reset("rnd");
      nj = $urandom_range(2, 0);
      for (int j = 0; j < nj; j++) send_byte(junk_byte(), $urandom_range(2, 0));
      send_frame("rnd", 20'($urandom), 4'($urandom), $urandom_range(3, 1),
                 ($urandom_range(3, 0) == 0), 1'b0, 1'b1, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
